// File: rtl/seg_src_arbiter.sv
// Two-source arbiter for the 595 segment display. Enforces a minimum ownership time.
// Define SEG_ARB_RR_EN for round-robin; the default build uses fixed priority with A first.
module seg_src_arbiter #(
   parameter logic [23:0] HOLD_MAX = 24'd9_999_999
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        req_a,
   input  logic [19:0] data_a,
   input  logic [5:0]  point_a,
   input  logic        sign_a,
   input  logic        req_b,
   input  logic [19:0] data_b,
   input  logic [5:0]  point_b,
   input  logic        sign_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [19:0] data,
   output logic [5:0]  point,
   output logic        sign,
   output logic        seg_en,
   output logic [1:0]  dbg_state
);

   // Handshake: req_x is a level; the owner keeps the display until it drops req_x,
   // or until the hold time has expired and the other source is allowed to preempt.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] hold_cnt_q, hold_cnt_d;
   logic        hold_expired;
   logic        tie_to_b;
   logic        a_yields;
   logic        gnt_a_q, gnt_b_q, seg_en_q, sign_q, sign_d;
   logic [19:0] data_q, data_d;
   logic [5:0]  point_q, point_d;

`ifdef SEG_ARB_RR_EN
   logic last_owner_q;   // 1 = A owned last, 0 = B owned last
   logic last_owner_d;

   assign tie_to_b = last_owner_q;
   assign a_yields = 1'b1;

   always_comb begin
      last_owner_d = last_owner_q;
      if (state_d == OWN_A && state_q != OWN_A) last_owner_d = 1'b1;
      else if (state_d == OWN_B && state_q != OWN_B) last_owner_d = 1'b0;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) last_owner_q <= 1'b0;
      else            last_owner_q <= last_owner_d;
   end
`else
   assign tie_to_b = 1'b0;
   assign a_yields = 1'b0;
`endif

   assign hold_expired = (hold_cnt_q == HOLD_MAX);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_a && req_b) state_d = tie_to_b ? OWN_B : OWN_A;
            else if (req_a)     state_d = OWN_A;
            else if (req_b)     state_d = OWN_B;
         end
         OWN_A: begin
            if (!req_a)                                 state_d = req_b ? OWN_B : IDLE;
            else if (hold_expired && req_b && a_yields) state_d = OWN_B;
         end
         OWN_B: begin
            if (!req_b)                     state_d = req_a ? OWN_A : IDLE;
            else if (hold_expired && req_a) state_d = OWN_A;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (state_d != state_q)                    hold_cnt_d = 24'd0;
      else if (state_q != IDLE && !hold_expired) hold_cnt_d = hold_cnt_q + 24'd1;
   end

   // The mux follows the next owner so that data switches on the same edge as the grant.
   always_comb begin
      data_d  = 20'd0;
      point_d = 6'd0;
      sign_d  = 1'b0;
      if (state_d == OWN_A) begin
         data_d  = data_a;
         point_d = point_a;
         sign_d  = sign_a;
      end else if (state_d == OWN_B) begin
         data_d  = data_b;
         point_d = point_b;
         sign_d  = sign_b;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         hold_cnt_q <= 24'd0;
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         seg_en_q   <= 1'b0;
         data_q     <= 20'd0;
         point_q    <= 6'd0;
         sign_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_a_q    <= (state_d == OWN_A);
         gnt_b_q    <= (state_d == OWN_B);
         seg_en_q   <= (state_d != IDLE);
         data_q     <= data_d;
         point_q    <= point_d;
         sign_q     <= sign_d;
      end
   end

   assign gnt_a     = gnt_a_q;
   assign gnt_b     = gnt_b_q;
   assign seg_en    = seg_en_q;
   assign data      = data_q;
   assign point     = point_q;
   assign sign      = sign_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_src_arbiter.sv
// Bench for seg_src_arbiter: directed scenarios followed by random traffic.
// A small ownership model predicts grants and forwarded data.
module tb_seg_src_arbiter;

   localparam logic [23:0] HOLD   = 24'd10;
   localparam int          HOLD_I = 10;
`ifdef SEG_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        req_a = 1'b0, req_b = 1'b0;
   logic [19:0] data_a = 20'd0, data_b = 20'd0;
   logic [5:0]  point_a = 6'd0, point_b = 6'd0;
   logic        sign_a = 1'b0, sign_b = 1'b0;
   logic        gnt_a, gnt_b, sign, seg_en;
   logic [19:0] data;
   logic [5:0]  point;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Ownership model: owner 0 = nobody, 1 = A, 2 = B; grant_edge = edge number of the last grant
   int cyc = 0;
   int m_owner = 0;
   int m_grant_edge = 0;
   int m_last = 2;
   logic        e_gnt_a = 1'b0, e_gnt_b = 1'b0, e_seg_en = 1'b0, e_sign = 1'b0;
   logic [19:0] e_data = 20'd0;
   logic [5:0]  e_point = 6'd0;

   seg_src_arbiter #(.HOLD_MAX(HOLD)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .req_a     (req_a),
      .data_a    (data_a),
      .point_a   (point_a),
      .sign_a    (sign_a),
      .req_b     (req_b),
      .data_b    (data_b),
      .point_b   (point_b),
      .sign_b    (sign_b),
      .gnt_a     (gnt_a),
      .gnt_b     (gnt_b),
      .data      (data),
      .point     (point),
      .sign      (sign),
      .seg_en    (seg_en),
      .dbg_state (dbg_state)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".gnt_a"},  32'(gnt_a),  32'(e_gnt_a));
      check({tag, ".gnt_b"},  32'(gnt_b),  32'(e_gnt_b));
      check({tag, ".seg_en"}, 32'(seg_en), 32'(e_seg_en));
      check({tag, ".data"},   32'(data),   32'(e_data));
      check({tag, ".point"},  32'(point),  32'(e_point));
      check({tag, ".sign"},   32'(sign),   32'(e_sign));
   endtask

   // Apply requests, predict the next owner, clock once and compare.
   task automatic step(input string tag, input logic a, input logic b);
      int  e;
      int  nxt;
      bit  expired;
      req_a = a;
      req_b = b;
      e = cyc + 1;
      expired = (m_owner != 0) && ((e - 1 - m_grant_edge) >= HOLD_I);
      nxt = m_owner;
      if (m_owner == 0) begin
         if (a && b)  nxt = (RR && m_last == 1) ? 2 : 1;
         else if (a)  nxt = 1;
         else if (b)  nxt = 2;
      end else if (m_owner == 1) begin
         if (!a)                       nxt = b ? 2 : 0;
         else if (b && expired && RR)  nxt = 2;
      end else begin
         if (!b)                 nxt = a ? 1 : 0;
         else if (a && expired)  nxt = 1;
      end
      if (nxt != m_owner) begin
         m_grant_edge = e;
         if (nxt != 0) m_last = nxt;
      end
      m_owner  = nxt;
      e_gnt_a  = (nxt == 1);
      e_gnt_b  = (nxt == 2);
      e_seg_en = (nxt != 0);
      e_data   = (nxt == 1) ? data_a  : (nxt == 2) ? data_b  : 20'd0;
      e_point  = (nxt == 1) ? point_a : (nxt == 2) ? point_b : 6'd0;
      e_sign   = (nxt == 1) ? sign_a  : (nxt == 2) ? sign_b  : 1'b0;
      @(posedge sys_clk);
      cyc = e;
      #1;
      check_outputs(tag);
   endtask

   // Reset is asserted between edges; outputs must clear without a clock.
   task automatic do_reset(input string tag);
      sys_rst_n = 1'b0;
      #1;
      m_owner  = 0;
      m_last   = 2;
      e_gnt_a  = 1'b0;
      e_gnt_b  = 1'b0;
      e_seg_en = 1'b0;
      e_data   = 20'd0;
      e_point  = 6'd0;
      e_sign   = 1'b0;
      check_outputs(tag);
      #2;
      sys_rst_n = 1'b1;
   endtask

   initial begin
      do_reset("reset");

      // Single source A takes the display after one clock
      data_a  = 20'd123456;
      point_a = 6'b000100;
      sign_a  = 1'b0;
      data_b  = 20'd777;
      point_b = 6'b100000;
      sign_b  = 1'b1;
      step("grant_a", 1'b1, 1'b0);
      check("grant_a.gnt",   32'(gnt_a),  32'd1);
      check("grant_a.data",  32'(data),   32'd123456);
      check("grant_a.point", 32'(point),  32'b000100);
      check("grant_a.en",    32'(seg_en), 32'd1);

      // Hold time: B asks while A's counter is 3
      for (int i = 0; i < 3; i++) step("hold_pre", 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step("hold_wait", 1'b1, 1'b1);
         check("hold_wait.gnt_a", 32'(gnt_a), 32'd1);
      end
`ifdef SEG_ARB_RR_EN
      step("hold_handover", 1'b1, 1'b1);
      check("hold_handover.gnt_b", 32'(gnt_b), 32'd1);
      check("hold_handover.data",  32'(data),  32'd777);
`else
      for (int i = 0; i < 20; i++) begin
         step("hold_keep", 1'b1, 1'b1);
         check("hold_keep.gnt_a", 32'(gnt_a), 32'd1);
      end
`endif
      step("drop_both", 1'b0, 1'b0);

      // Ties from reset, then a second tie
      do_reset("reset_tie");
      step("tie1", 1'b1, 1'b1);
      check("tie1.gnt_a", 32'(gnt_a), 32'd1);
      step("tie_idle", 1'b0, 1'b0);
      step("tie2", 1'b1, 1'b1);
`ifdef SEG_ARB_RR_EN
      check("tie2.gnt_b", 32'(gnt_b), 32'd1);
`else
      check("tie2.gnt_a", 32'(gnt_a), 32'd1);
`endif
      step("tie_idle2", 1'b0, 1'b0);

      // B owns alone and drops at counter 2
      step("b_own", 1'b0, 1'b1);
      step("b_c1", 1'b0, 1'b1);
      step("b_c2", 1'b0, 1'b1);
      step("b_drop", 1'b0, 1'b0);
      check("b_drop.en",   32'(seg_en), 32'd0);
      check("b_drop.data", 32'(data),   32'd0);
      check("b_drop.gnt",  32'(gnt_b),  32'd0);

      // Reset in the middle of B's ownership, then a tie goes to A
      step("b_own2", 1'b0, 1'b1);
      step("b_own2b", 1'b0, 1'b1);
      do_reset("reset_mid");
      step("tie_after_rst", 1'b1, 1'b1);
      check("tie_after_rst.gnt_a", 32'(gnt_a), 32'd1);
      step("idle3", 1'b0, 1'b0);

      // One-cycle request pulse
      step("pulse_on", 1'b1, 1'b0);
      check("pulse_on.gnt_a", 32'(gnt_a), 32'd1);
      step("pulse_off", 1'b0, 1'b0);
      check("pulse_off.gnt_a", 32'(gnt_a), 32'd0);

      // Random traffic: requests mostly persist so hold expiry gets exercised
      for (int i = 0; i < 400; i++) begin
         logic ra, rb;
         ra = ($urandom_range(0, 9) < 8) ? req_a : ~req_a;
         rb = ($urandom_range(0, 9) < 8) ? req_b : ~req_b;
         data_a  = 20'($urandom_range(0, 20'hFFFFF));
         data_b  = 20'($urandom_range(0, 20'hFFFFF));
         point_a = 6'($urandom_range(0, 63));
         point_b = 6'($urandom_range(0, 63));
         sign_a  = 1'($urandom_range(0, 1));
         sign_b  = 1'($urandom_range(0, 1));
         step("rand", ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
